sr_imem_loader: RTL
===================

Name: sr_imem_loader

Overview:
- Instruction-memory responder for the single-cycle CPU: answers the core's word-address fetch (imAddr in, imData out) combinationally from an on-chip word array.
- Also owns a byte-stream program-load port with a valid/ready handshake. Bytes are assembled little-endian into words and written sequentially from word 0.
- Holds the CPU in reset (cpuRst_n) while no program is loaded or a load is in progress.

Parameters:
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words.
- NOP_WORD, 32'h00000013, value returned for fetches outside the array (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- imAddr  in  32  word address from CPU fetch
- imData  out  32  instruction word to CPU
- ldStart  in  1  single-cycle request to begin a load
- ldData  in  8  load byte
- ldValid  in  1  ldData valid
- ldLast  in  1  qualifies the final byte of the stream (sampled with ldValid)
- ldReady  out  1  loader accepts a byte this cycle
- cpuRst_n  out  1  active-low reset to the CPU, registered
- ldWords  out  ADDR_W+1  words written since the last ldStart, saturating at DEPTH
- ldErr  out  1  sticky overflow flag

Behaviour:
- Reset (async, rst_n low):
  - state=HALT; byteCnt=0; wordAddr=0; shift register=0.
  - Outputs: ldWords=0, ldErr=0, ldReady=0, cpuRst_n=0.
  - Memory array is not reset; its contents are retained across reset.
- States:
  - HALT: ldReady=0, cpuRst_n=0.
  - LOAD: ldReady=1, cpuRst_n=0.
  - DONE: ldReady=0, cpuRst_n=0; lasts exactly 1 cycle.
  - RUN: ldReady=0, cpuRst_n=1.
- Transitions:
  - HALT -> LOAD when ldStart=1.
  - RUN -> LOAD when ldStart=1. cpuRst_n goes low in the cycle after the sampling edge.
  - ldStart in LOAD or DONE is ignored.
  - LOAD -> DONE on an accepted byte with ldLast=1.
  - DONE -> RUN unconditionally.
- Entering LOAD: byteCnt, wordAddr, ldWords and ldErr are cleared.
- Handshake: a byte is accepted on a clock edge where ldValid & ldReady. No other cycle changes byteCnt. ldData/ldLast are ignored outside accepted cycles.
- Word assembly (little-endian): byte k of a word (k = byteCnt) goes to bits [8k+7:8k]. byteCnt wraps 3 -> 0.
- A word write occurs on the accepting edge when byteCnt==3, or when ldLast=1 with any byteCnt.
  - On a ldLast write, unfilled upper bytes are written as 0.
  - The write goes to mem[wordAddr]; then wordAddr++ and ldWords++.
- Overflow: a write attempted with wordAddr==DEPTH is dropped.
  - Memory is unchanged; ldErr is set to 1 and held until the next LOAD entry.
  - ldWords stays at DEPTH.
  - The loader continues accepting bytes until ldLast.
- Fetch: imData = mem[imAddr[ADDR_W-1:0]] when imAddr[31:ADDR_W]==0, else NOP_WORD.
  - Purely combinational; zero-cycle latency.
  - A word written at edge N is visible on imData from the cycle after edge N.
- Reset mid-load: returns to HALT. A partially assembled word is discarded (never written). Words already written remain in memory.
- ldStart and an accepted byte are never simultaneous, because ldReady=0 in HALT/RUN.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> immediately cpuRst_n=0, ldReady=0, ldWords=0, ldErr=0; state HALT persists with ldStart=0.
- Full-word load: ldStart, then bytes 13 00 10 00 93 00 20 00 (ldLast on the 8th) ->
  - mem[0]=0x00100013, mem[1]=0x00200093, ldWords=2;
  - exactly 1 DONE cycle, then cpuRst_n=1;
  - imAddr=1 -> imData=0x00200093.
- Partial last word: bytes AA BB CC DD EE (last on EE) -> mem[0]=0xDDCCBBAA, mem[1]=0x000000EE, ldWords=2, ldErr=0.
- Backpressure/gaps: ldValid pattern 1,0,0,1,1,0,1 with ldLast on the 4th accepted byte -> one word written, only handshaked bytes counted; ldStart pulsed during LOAD has no effect.
- Overflow (ADDR_W=2): 5 full words streamed -> ldWords=4, ldErr=1, mem[0..3] hold words 0..3 (5th dropped), RUN reached after ldLast; next ldStart clears ldErr.
- Reset mid-load after 3 bytes of word 1 (word 0 already written) -> HALT, cpuRst_n=0, mem[0] retained, mem[1] unchanged; with ADDR_W=6, imAddr=0x40 -> imData=0x00000013.

Source files
------------

// File: rtl/sr_imem_loader.sv
// Instruction memory for the single-cycle core with a byte-stream program loader.
// Holds the CPU in reset until a complete program has been streamed in.
module sr_imem_loader #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       imAddr,
  output logic [31:0]       imData,
  input  logic              ldStart,
  input  logic [7:0]        ldData,
  input  logic              ldValid,
  input  logic              ldLast,
  output logic              ldReady,
  output logic              cpuRst_n,
  output logic [ADDR_W:0]   ldWords,
  output logic              ldErr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {HALT, LOAD, DONE, RUN} state_t;

  state_t          state;
  logic [1:0]      byteCnt;
  logic [ADDR_W:0] wordAddr;
  logic [31:0]     shiftReg;
  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            wrReq;
  logic            full;
  logic            wrEn;
  logic [31:0]     asmWord;

  assign accept = ldValid & ldReady;
  assign wrReq  = accept & ((byteCnt == 2'd3) | ldLast);
  assign full   = (wordAddr == DEPTH_W);
  assign wrEn   = wrReq & ~full;

  // shiftReg is cleared after every write, so a short final word has zero upper bytes.
  always_comb begin
    asmWord = shiftReg;
    asmWord[{byteCnt, 3'b000} +: 8] = ldData;
  end

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wordAddr[ADDR_W-1:0]] <= asmWord;
    end
  end

  always_comb begin
    imData = NOP_WORD;
    if (imAddr[31:ADDR_W] == '0) begin
      imData = mem[imAddr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HALT;
      byteCnt  <= '0;
      wordAddr <= '0;
      shiftReg <= '0;
      ldWords  <= '0;
      ldErr    <= 1'b0;
      ldReady  <= 1'b0;
      cpuRst_n <= 1'b0;
    end else begin
      case (state)
        HALT, RUN: begin
          if (ldStart) begin
            state    <= LOAD;
            ldReady  <= 1'b1;
            cpuRst_n <= 1'b0;
            byteCnt  <= '0;
            wordAddr <= '0;
            shiftReg <= '0;
            ldWords  <= '0;
            ldErr    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            byteCnt <= byteCnt + 2'd1;
            if (wrReq) begin
              shiftReg <= '0;
              if (full) begin
                ldErr <= 1'b1;
              end else begin
                wordAddr <= wordAddr + ONE_W;
                ldWords  <= ldWords + ONE_W;
              end
            end else begin
              shiftReg <= asmWord;
            end
            if (ldLast) begin
              state   <= DONE;
              ldReady <= 1'b0;
            end
          end
        end
        DONE: begin
          state    <= RUN;
          cpuRst_n <= 1'b1;
        end
        default: begin
          state    <= HALT;
          ldReady  <= 1'b0;
          cpuRst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
